// File: rtl/hack_cpu.sv
//==============================================================================
// hack_cpu : single-cycle Hack CPU (A/D/PC registers, decode, jump) around hack_alu
// Rev 1.0
//==============================================================================
`default_nettype none

module hack_alu (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic        zx_i,
  input  logic        nx_i,
  input  logic        zy_i,
  input  logic        ny_i,
  input  logic        f_i,
  input  logic        no_i,
  output logic [15:0] out_o,
  output logic        zr_o,
  output logic        ng_o
);
  logic [15:0] x1, x2, y1, y2, fo;

  assign x1    = zx_i ? 16'h0000 : x_i;
  assign x2    = nx_i ? ~x1 : x1;
  assign y1    = zy_i ? 16'h0000 : y_i;
  assign y2    = ny_i ? ~y1 : y1;
  assign fo    = f_i ? (x2 + y2) : (x2 & y2);
  assign out_o = no_i ? ~fo : fo;
  assign zr_o  = (out_o == 16'h0000);
  assign ng_o  = out_o[15];
endmodule

module hack_cpu #(
  parameter int unsigned PC_W   = 15,
  parameter int unsigned RST_PC = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ce_i,
  input  logic [15:0]     inst_i,
  input  logic [15:0]     in_m_i,
  output logic [15:0]     out_m_o,
  output logic            write_m_o,
  output logic [PC_W-1:0] addr_o,
  output logic [PC_W-1:0] pc_o
);
  localparam logic [PC_W-1:0] C_RST_PC = PC_W'(RST_PC);
  localparam logic [PC_W-1:0] C_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [15:0]     a_q, a_d;
  logic [15:0]     d_q, d_d;
  logic [PC_W-1:0] pc_q, pc_d;

  logic            is_c, dest_a, dest_d, dest_m, take;
  logic [15:0]     alu_y, alu_out;
  logic            alu_zr, alu_ng;
  logic            unused_ok;

  assign is_c   = inst_i[15];
  assign dest_a = inst_i[5];
  assign dest_d = inst_i[4];
  assign dest_m = inst_i[3];
  assign alu_y  = inst_i[12] ? in_m_i : a_q;
  // inst[14:13] carry no meaning in a C-instruction
  assign unused_ok = ^inst_i[14:13];

  hack_alu u_alu (
    .x_i   (d_q),
    .y_i   (alu_y),
    .zx_i  (inst_i[11]),
    .nx_i  (inst_i[10]),
    .zy_i  (inst_i[9]),
    .ny_i  (inst_i[8]),
    .f_i   (inst_i[7]),
    .no_i  (inst_i[6]),
    .out_o (alu_out),
    .zr_o  (alu_zr),
    .ng_o  (alu_ng)
  );

  assign take = (inst_i[2] & alu_ng) | (inst_i[1] & alu_zr) |
                (inst_i[0] & ~alu_ng & ~alu_zr);

  always_comb begin
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q + C_PC_ONE;
    if (!is_c) begin
      a_d = {1'b0, inst_i[14:0]};
    end else begin
      if (dest_a) a_d = alu_out;
      if (dest_d) d_d = alu_out;
      // jump target is the pre-update A even when dA is also set
      if (take) pc_d = a_q[PC_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q  <= 16'h0000;
      d_q  <= 16'h0000;
      pc_q <= C_RST_PC;
    end else if (ce_i) begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

  assign out_m_o   = alu_out;
  assign write_m_o = ~rst_i & is_c & dest_m & ce_i;
  assign addr_o    = a_q[PC_W-1:0];
  assign pc_o      = pc_q;
endmodule

`default_nettype wire

// File: tb/tb_hack_cpu.sv
//==============================================================================
// tb_hack_cpu : directed self-checking bench for hack_cpu
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_hack_cpu;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ce_i;
  logic [15:0] inst_i;
  logic [15:0] in_m_i;
  logic [15:0] out_m_o;
  logic        write_m_o;
  logic [14:0] addr_o;
  logic [14:0] pc_o;

  int n_checks = 0;
  int n_pass   = 0;

  hack_cpu #(.PC_W(15), .RST_PC(0)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ce_i      (ce_i),
    .inst_i    (inst_i),
    .in_m_i    (in_m_i),
    .out_m_o   (out_m_o),
    .write_m_o (write_m_o),
    .addr_o    (addr_o),
    .pc_o      (pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // apply an instruction and let one rising edge execute it
  task automatic run(input logic [15:0] ins, input logic [15:0] m);
    inst_i = ins;
    in_m_i = m;
    @(posedge clk_i);
    #1;
  endtask

  // expose D on out_m_o using comp=D with no dest and no jump
  task automatic peek_d(input string tag, input logic [15:0] exp);
    inst_i = 16'hE300;
    #1;
    check(tag, out_m_o, exp);
  endtask

  initial begin
    rst_i  = 1'b1;
    ce_i   = 1'b1;
    inst_i = 16'hE7C8;
    in_m_i = 16'h0000;
    #2;
    check("rst_pc",    {1'b0, pc_o}, 16'd0);
    check("rst_addr",  {1'b0, addr_o}, 16'd0);
    check("rst_wr",    {15'd0, write_m_o}, 16'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // @21 ; D=A ; M=D+1
    run(16'h0015, 16'h0000);
    check("a_addr", {1'b0, addr_o}, 16'd21);
    check("a_pc",   {1'b0, pc_o}, 16'd1);
    run(16'hEC10, 16'h0000);
    check("dA_pc",  {1'b0, pc_o}, 16'd2);
    peek_d("dA_d", 16'd21);
    inst_i = 16'hE7C8;
    #1;
    check("mdp1_out",  out_m_o, 16'd22);
    check("mdp1_wr",   {15'd0, write_m_o}, 16'd1);
    check("mdp1_addr", {1'b0, addr_o}, 16'd21);
    run(16'hE7C8, 16'h0000);
    check("mdp1_pc", {1'b0, pc_o}, 16'd3);

    // @7 ; AM=M-1 with M=5
    run(16'h0007, 16'h0000);
    inst_i = 16'hFCA8;
    in_m_i = 16'd5;
    #1;
    check("rmw_out",  out_m_o, 16'd4);
    check("rmw_wr",   {15'd0, write_m_o}, 16'd1);
    check("rmw_addr", {1'b0, addr_o}, 16'd7);
    run(16'hFCA8, 16'd5);
    check("rmw_a",  {1'b0, addr_o}, 16'd4);
    check("rmw_pc", {1'b0, pc_o}, 16'd5);

    // clock enable held low during M=D+1
    inst_i = 16'hE7C8;
    in_m_i = 16'h0000;
    ce_i   = 1'b0;
    #1;
    check("ce_wr",  {15'd0, write_m_o}, 16'd0);
    check("ce_out", out_m_o, 16'd22);
    for (int i = 0; i < 3; i++) begin
      run(16'hE7C8, 16'h0000);
      check("ce_pc",   {1'b0, pc_o}, 16'd5);
      check("ce_addr", {1'b0, addr_o}, 16'd4);
      peek_d("ce_d", 16'd21);
    end
    ce_i   = 1'b1;
    inst_i = 16'hE7C8;
    #1;
    check("ce_resume_wr", {15'd0, write_m_o}, 16'd1);
    run(16'hE7C8, 16'h0000);
    check("ce_resume_pc", {1'b0, pc_o}, 16'd6);

    // jumps with A=100
    run(16'h0064, 16'h0000);
    run(16'hEA87, 16'h0000);
    check("jmp", {1'b0, pc_o}, 16'd100);
    run(16'hEE90, 16'h0000);
    peek_d("d_neg1", 16'hFFFF);
    run(16'hE301, 16'h0000);
    check("jgt_nt", {1'b0, pc_o}, 16'd102);
    run(16'hE304, 16'h0000);
    check("jlt_t", {1'b0, pc_o}, 16'd100);
    run(16'hEA90, 16'h0000);
    check("d0_pc", {1'b0, pc_o}, 16'd101);
    run(16'hE302, 16'h0000);
    check("jeq_t", {1'b0, pc_o}, 16'd100);
    // A=1;JMP targets the old A
    run(16'hEFE7, 16'h0000);
    check("dajmp_pc", {1'b0, pc_o}, 16'd100);
    check("dajmp_a",  {1'b0, addr_o}, 16'd1);

    // PC wrap 32767 -> 0
    run(16'h7FFF, 16'h0000);
    run(16'hEA87, 16'h0000);
    check("wrap_pre", {1'b0, pc_o}, 16'd32767);
    run(16'h0003, 16'h0000);
    check("wrap_pc",   {1'b0, pc_o}, 16'd0);
    check("wrap_addr", {1'b0, addr_o}, 16'd3);

    // set A=7, PC=9, then reset asynchronously mid-cycle
    run(16'h0007, 16'h0000);
    run(16'hEC10, 16'h0000);
    run(16'h0009, 16'h0000);
    run(16'hE327, 16'h0000);
    check("pre_rst_pc",   {1'b0, pc_o}, 16'd9);
    check("pre_rst_addr", {1'b0, addr_o}, 16'd7);
    inst_i = 16'hE7C8;
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_pc",   {1'b0, pc_o}, 16'd0);
    check("arst_addr", {1'b0, addr_o}, 16'd0);
    check("arst_wr",   {15'd0, write_m_o}, 16'd0);
    @(posedge clk_i);
    #1;
    check("arst_hold_pc", {1'b0, pc_o}, 16'd0);
    check("arst_hold_wr", {15'd0, write_m_o}, 16'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    peek_d("arst_d", 16'd0);
    run(16'h0015, 16'h0000);
    check("post_rst_addr", {1'b0, addr_o}, 16'd21);
    check("post_rst_pc",   {1'b0, pc_o}, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
